// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: default widths, register-address
// width, writeback source selects and the hardwired-zero register index.
package wb_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned PC_W     = 16;
  localparam int unsigned REG_AW   = 3;
  localparam int unsigned NUM_REGS = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  localparam reg_addr_t R0_IDX = '0;

endpackage

// File: rtl/writeback_unit_if.sv
// Writeback bus: retire/issue control from the decode register chain and the
// operand read/hazard results returned to decode.
interface writeback_unit_if #(
  parameter int unsigned DATA_W = wb_pkg::DATA_W,
  parameter int unsigned PC_W   = wb_pkg::PC_W
);
  import wb_pkg::*;

  reg_addr_t         writeAd_IN;
  logic              write_IN;
  logic              ADR_MUX_IN;
  logic              PC_load_IN;
  logic [DATA_W-1:0] aluData_IN;
  logic [DATA_W-1:0] memData_IN;
  logic              stall_IN;
  reg_addr_t         issueAd_IN;
  logic              issue_IN;
  reg_addr_t         readAdA_IN;
  reg_addr_t         readAdB_IN;
  logic [DATA_W-1:0] readDataA_OUT;
  logic [DATA_W-1:0] readDataB_OUT;
  logic [PC_W-1:0]   PC_OUT;
  logic              hazard_OUT;

  modport master (
    output writeAd_IN, write_IN, ADR_MUX_IN, PC_load_IN, aluData_IN, memData_IN,
           stall_IN, issueAd_IN, issue_IN, readAdA_IN, readAdB_IN,
    input  readDataA_OUT, readDataB_OUT, PC_OUT, hazard_OUT
  );

  modport slave (
    input  writeAd_IN, write_IN, ADR_MUX_IN, PC_load_IN, aluData_IN, memData_IN,
           stall_IN, issueAd_IN, issue_IN, readAdA_IN, readAdB_IN,
    output readDataA_OUT, readDataB_OUT, PC_OUT, hazard_OUT
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// retire (set wins on collision), plus hazard lookup for two read ports.
// Optional feature macro: WB_BYPASS_EN (same-cycle forwarding masks hazards).
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      issue_i,
  input  reg_addr_t issue_ad_i,
  input  logic      write_i,
  input  reg_addr_t write_ad_i,
  input  reg_addr_t rd_ad_a_i,
  input  reg_addr_t rd_ad_b_i,
  output logic      byp_a_o,
  output logic      byp_b_o,
  output logic      hazard_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Next pending vector: clear first so a same-register issue overrides it.
  always_comb begin
    pending_d = pending_q;
    if (write_i) begin
      pending_d[write_ad_i] = 1'b0;
    end
    if (issue_i && (issue_ad_i != R0_IDX)) begin
      pending_d[issue_ad_i] = 1'b1;
    end
  end

  // Pending vector register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

`ifdef WB_BYPASS_EN
  // A retiring write to a read address forwards this cycle, so no stall needed.
  assign byp_a_o = write_i && (write_ad_i == rd_ad_a_i) && (rd_ad_a_i != R0_IDX);
  assign byp_b_o = write_i && (write_ad_i == rd_ad_b_i) && (rd_ad_b_i != R0_IDX);
`else
  assign byp_a_o = 1'b0;
  assign byp_b_o = 1'b0;
`endif

  assign hazard_o = ((rd_ad_a_i != R0_IDX) && pending_q[rd_ad_a_i] && !byp_a_o) ||
                    ((rd_ad_b_i != R0_IDX) && pending_q[rd_ad_b_i] && !byp_b_o);

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: selects writeback data, commits it to an 8-entry
// register file (R0 hardwired to zero) and the PC, and reports RAW hazards.
// Optional feature macro: WB_BYPASS_EN (forwarding handled in wb_scoreboard).
module writeback_unit #(
  parameter int unsigned DATA_W = wb_pkg::DATA_W,
  parameter int unsigned PC_W   = wb_pkg::PC_W
) (
  input logic             CLK,
  input logic             RST,
  writeback_unit_if.slave wb
);
  import wb_pkg::*;

  logic [DATA_W-1:0] wb_data;
  logic [PC_W-1:0]   wb_pc;
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              byp_a, byp_b;
  logic              hazard;

  assign wb_data = (wb.ADR_MUX_IN == WB_SEL_MEM) ? wb.memData_IN : wb.aluData_IN;

  // PC load value: zero-extend or truncate writeback data to PC width.
  if (PC_W > DATA_W) begin : g_pc_ext
    assign wb_pc = {{(PC_W - DATA_W){1'b0}}, wb_data};
  end else begin : g_pc_trunc
    assign wb_pc = wb_data[PC_W-1:0];
  end

  // Register file write; R0 is never written and stays at its reset value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb.write_IN && (wb.writeAd_IN != R0_IDX)) begin
      rf_q[wb.writeAd_IN] <= wb_data;
    end
  end

  // Program counter: load beats increment, stall holds.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q <= '0;
    end else if (wb.PC_load_IN) begin
      pc_q <= wb_pc;
    end else if (!wb.stall_IN) begin
      pc_q <= pc_q + PC_W'(1);
    end
  end

  // Operand reads: R0 reads zero, forwarded data replaces stored contents.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (wb.readAdA_IN != R0_IDX) begin
      rd_a = rf_q[wb.readAdA_IN];
    end
    if (wb.readAdB_IN != R0_IDX) begin
      rd_b = rf_q[wb.readAdB_IN];
    end
    if (byp_a) begin
      rd_a = wb_data;
    end
    if (byp_b) begin
      rd_b = wb_data;
    end
  end

  wb_scoreboard u_scoreboard (
    .CLK        (CLK),
    .RST        (RST),
    .issue_i    (wb.issue_IN),
    .issue_ad_i (wb.issueAd_IN),
    .write_i    (wb.write_IN),
    .write_ad_i (wb.writeAd_IN),
    .rd_ad_a_i  (wb.readAdA_IN),
    .rd_ad_b_i  (wb.readAdB_IN),
    .byp_a_o    (byp_a),
    .byp_b_o    (byp_b),
    .hazard_o   (hazard)
  );

  assign wb.readDataA_OUT = rd_a;
  assign wb.readDataB_OUT = rd_b;
  assign wb.PC_OUT        = pc_q;
  assign wb.hazard_OUT    = hazard;

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus randomized
// traffic compared against a behavioural register/PC/pending model.
module tb_writeback_unit;

`ifdef WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic CLK;
  logic RST;

  writeback_unit_if #(.DATA_W(16), .PC_W(16)) bus ();

  writeback_unit #(.DATA_W(16), .PC_W(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .wb  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_rf [8];
  logic [15:0] m_pc;
  bit          m_pend [8];

  function automatic logic [15:0] m_wb();
    return bus.ADR_MUX_IN ? bus.memData_IN : bus.aluData_IN;
  endfunction

  function automatic bit m_fwd(logic [2:0] a);
    return Bypass && bus.write_IN && (bus.writeAd_IN == a) && (a != 3'd0);
  endfunction

  function automatic logic [15:0] m_read(logic [2:0] a);
    if (a == 3'd0) return 16'h0000;
    if (m_fwd(a)) return m_wb();
    return m_rf[a];
  endfunction

  function automatic logic m_hazard();
    logic ha, hb;
    ha = (bus.readAdA_IN != 3'd0) && m_pend[bus.readAdA_IN] && !m_fwd(bus.readAdA_IN);
    hb = (bus.readAdB_IN != 3'd0) && m_pend[bus.readAdB_IN] && !m_fwd(bus.readAdB_IN);
    return ha || hb;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_rf[i]   = 16'h0000;
      m_pend[i] = 1'b0;
    end
    m_pc = 16'h0000;
  endtask

  // Apply one rising edge's worth of architectural effects.
  task automatic model_edge();
    logic [15:0] d;
    d = m_wb();
    if (bus.write_IN && bus.writeAd_IN != 3'd0) m_rf[bus.writeAd_IN] = d;
    if (bus.PC_load_IN) m_pc = d;
    else if (!bus.stall_IN) m_pc = m_pc + 16'd1;
    if (bus.write_IN) m_pend[bus.writeAd_IN] = 1'b0;
    if (bus.issue_IN && bus.issueAd_IN != 3'd0) m_pend[bus.issueAd_IN] = 1'b1;
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.writeAd_IN = 3'd0;
    bus.write_IN   = 1'b0;
    bus.ADR_MUX_IN = 1'b0;
    bus.PC_load_IN = 1'b0;
    bus.aluData_IN = 16'h0000;
    bus.memData_IN = 16'h0000;
    bus.stall_IN   = 1'b1;
    bus.issueAd_IN = 3'd0;
    bus.issue_IN   = 1'b0;
    bus.readAdA_IN = 3'd0;
    bus.readAdB_IN = 3'd0;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    #1;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    idle_inputs();
    for (int a = 0; a < 8; a++) begin
      bus.readAdA_IN = 3'(a);
      bus.readAdB_IN = 3'(7 - a);
      #1;
      n_checks++;
      if (bus.readDataA_OUT !== 16'h0000 || bus.readDataB_OUT !== 16'h0000) begin
        $display("FAIL reset_reads: addr %0d got %h/%h want 0000/0000", a,
                 bus.readDataA_OUT, bus.readDataB_OUT);
      end else n_pass++;
      n_checks++;
      if (bus.hazard_OUT !== 1'b0) begin
        $display("FAIL reset_hazard: addr %0d got %b want 0", a, bus.hazard_OUT);
      end else n_pass++;
    end
    n_checks++;
    if (bus.PC_OUT !== 16'h0000) begin
      $display("FAIL reset_pc: got %h want 0000", bus.PC_OUT);
    end else n_pass++;

    // Build up state: R3=0x1234, R5 pending, PC=0x0040.
    bus.write_IN = 1'b1; bus.writeAd_IN = 3'd3; bus.aluData_IN = 16'h1234;
    bus.issue_IN = 1'b1; bus.issueAd_IN = 3'd5;
    step();
    idle_inputs();
    bus.PC_load_IN = 1'b1; bus.aluData_IN = 16'h0040;
    step();
    idle_inputs();
    bus.readAdA_IN = 3'd3; bus.readAdB_IN = 3'd5;
    #1;
    n_checks++;
    if (bus.readDataA_OUT !== 16'h1234 || bus.hazard_OUT !== 1'b1 || bus.PC_OUT !== 16'h0040)
    begin
      $display("FAIL prereset_state: got r3=%h hz=%b pc=%h want 1234/1/0040",
               bus.readDataA_OUT, bus.hazard_OUT, bus.PC_OUT);
    end else n_pass++;

    // Mid-cycle asynchronous reset must clear everything at once.
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if (bus.PC_OUT !== 16'h0000 || bus.readDataA_OUT !== 16'h0000 ||
        bus.readDataB_OUT !== 16'h0000 || bus.hazard_OUT !== 1'b0) begin
      $display("FAIL async_reset: got pc=%h a=%h b=%h hz=%b want 0000/0000/0000/0",
               bus.PC_OUT, bus.readDataA_OUT, bus.readDataB_OUT, bus.hazard_OUT);
    end else n_pass++;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_mux_write();
    logic [15:0] exp_same;
    idle_inputs();
    bus.write_IN = 1'b1; bus.writeAd_IN = 3'd3; bus.ADR_MUX_IN = 1'b1;
    bus.memData_IN = 16'hBEEF; bus.aluData_IN = 16'h1111; bus.readAdA_IN = 3'd3;
    #1;
    exp_same = Bypass ? 16'hBEEF : m_rf[3];
    n_checks++;
    if (bus.readDataA_OUT !== exp_same) begin
      $display("FAIL mux_same_cycle: got %h want %h", bus.readDataA_OUT, exp_same);
    end else n_pass++;
    step();
    bus.write_IN = 1'b0;
    #1;
    n_checks++;
    if (bus.readDataA_OUT !== 16'hBEEF) begin
      $display("FAIL mux_after_edge: got %h want beef", bus.readDataA_OUT);
    end else n_pass++;

    // R0 write is discarded and never forwarded.
    bus.write_IN = 1'b1; bus.writeAd_IN = 3'd0; bus.ADR_MUX_IN = 1'b0;
    bus.aluData_IN = 16'hFFFF; bus.readAdA_IN = 3'd0; bus.readAdB_IN = 3'd0;
    #1;
    n_checks++;
    if (bus.readDataA_OUT !== 16'h0000 || bus.readDataB_OUT !== 16'h0000) begin
      $display("FAIL r0_same_cycle: got %h/%h want 0000/0000",
               bus.readDataA_OUT, bus.readDataB_OUT);
    end else n_pass++;
    step();
    bus.write_IN = 1'b0;
    #1;
    n_checks++;
    if (bus.readDataA_OUT !== 16'h0000) begin
      $display("FAIL r0_after_edge: got %h want 0000", bus.readDataA_OUT);
    end else n_pass++;
    idle_inputs();
  endtask

  task automatic test_pc();
    apply_reset();
    idle_inputs();
    bus.stall_IN = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++;
      if (bus.PC_OUT !== 16'(i)) begin
        $display("FAIL pc_incr: got %h want %h", bus.PC_OUT, 16'(i));
      end else n_pass++;
    end
    bus.stall_IN = 1'b1;
    step();
    n_checks++;
    if (bus.PC_OUT !== 16'h0003) begin
      $display("FAIL pc_stall: got %h want 0003", bus.PC_OUT);
    end else n_pass++;
    bus.PC_load_IN = 1'b1; bus.aluData_IN = 16'h0100;
    step();
    n_checks++;
    if (bus.PC_OUT !== 16'h0100) begin
      $display("FAIL pc_load_over_stall: got %h want 0100", bus.PC_OUT);
    end else n_pass++;
    bus.aluData_IN = 16'hFFFF;
    step();
    bus.PC_load_IN = 1'b0; bus.stall_IN = 1'b0;
    step();
    n_checks++;
    if (bus.PC_OUT !== 16'h0000) begin
      $display("FAIL pc_wrap: got %h want 0000", bus.PC_OUT);
    end else n_pass++;
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    logic exp_hz;
    idle_inputs();
    bus.issue_IN = 1'b1; bus.issueAd_IN = 3'd4; bus.readAdA_IN = 3'd4;
    #1;
    n_checks++;
    if (bus.hazard_OUT !== 1'b0) begin
      $display("FAIL sb_before_set: got %b want 0", bus.hazard_OUT);
    end else n_pass++;
    step();
    bus.issue_IN = 1'b0;
    #1;
    n_checks++;
    if (bus.hazard_OUT !== 1'b1) begin
      $display("FAIL sb_pending: got %b want 1", bus.hazard_OUT);
    end else n_pass++;
    bus.write_IN = 1'b1; bus.writeAd_IN = 3'd4; bus.aluData_IN = 16'h4444;
    #1;
    exp_hz = !Bypass;
    n_checks++;
    if (bus.hazard_OUT !== exp_hz) begin
      $display("FAIL sb_retire_same_cycle: got %b want %b", bus.hazard_OUT, exp_hz);
    end else n_pass++;
    step();
    bus.write_IN = 1'b0;
    #1;
    n_checks++;
    if (bus.hazard_OUT !== 1'b0 || bus.readDataA_OUT !== 16'h4444) begin
      $display("FAIL sb_retired: got hz=%b d=%h want 0/4444", bus.hazard_OUT,
               bus.readDataA_OUT);
    end else n_pass++;
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    bus.issue_IN = 1'b1; bus.issueAd_IN = 3'd2;
    bus.write_IN = 1'b1; bus.writeAd_IN = 3'd2; bus.aluData_IN = 16'h2222;
    step();
    idle_inputs();
    bus.readAdA_IN = 3'd2;
    #1;
    n_checks++;
    if (bus.hazard_OUT !== 1'b1 || bus.readDataA_OUT !== 16'h2222) begin
      $display("FAIL set_wins: got hz=%b d=%h want 1/2222", bus.hazard_OUT,
               bus.readDataA_OUT);
    end else n_pass++;
    bus.write_IN = 1'b1; bus.writeAd_IN = 3'd2;
    step();
    bus.write_IN = 1'b0;
    #1;
    n_checks++;
    if (bus.hazard_OUT !== 1'b0) begin
      $display("FAIL r2_cleared: got %b want 0", bus.hazard_OUT);
    end else n_pass++;
    bus.issue_IN = 1'b1; bus.issueAd_IN = 3'd0; bus.readAdA_IN = 3'd0; bus.readAdB_IN = 3'd0;
    step();
    bus.issue_IN = 1'b0;
    #1;
    n_checks++;
    if (bus.hazard_OUT !== 1'b0) begin
      $display("FAIL issue_r0: got %b want 0", bus.hazard_OUT);
    end else n_pass++;
    idle_inputs();
  endtask

  task automatic test_random();
    logic [15:0] ea, eb;
    logic        eh;
    int          errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      bus.writeAd_IN = 3'($urandom_range(0, 7));
      bus.write_IN   = 1'($urandom_range(0, 1));
      bus.ADR_MUX_IN = 1'($urandom_range(0, 1));
      bus.PC_load_IN = ($urandom_range(0, 7) == 0);
      bus.aluData_IN = 16'($urandom);
      bus.memData_IN = 16'($urandom);
      bus.stall_IN   = ($urandom_range(0, 3) == 0);
      bus.issueAd_IN = 3'($urandom_range(0, 7));
      bus.issue_IN   = 1'($urandom_range(0, 1));
      bus.readAdA_IN = 3'($urandom_range(0, 7));
      bus.readAdB_IN = 3'($urandom_range(0, 7));
      #1;
      ea = m_read(bus.readAdA_IN);
      eb = m_read(bus.readAdB_IN);
      eh = m_hazard();
      n_checks++;
      if (bus.readDataA_OUT !== ea || bus.readDataB_OUT !== eb) begin
        if (errs < 10) $display("FAIL rand_read: cyc %0d got %h/%h want %h/%h", c,
                                bus.readDataA_OUT, bus.readDataB_OUT, ea, eb);
        errs++;
      end else n_pass++;
      n_checks++;
      if (bus.hazard_OUT !== eh) begin
        if (errs < 10) $display("FAIL rand_hazard: cyc %0d got %b want %b", c,
                                bus.hazard_OUT, eh);
        errs++;
      end else n_pass++;
      n_checks++;
      if (bus.PC_OUT !== m_pc) begin
        if (errs < 10) $display("FAIL rand_pc: cyc %0d got %h want %h", c, bus.PC_OUT, m_pc);
        errs++;
      end else n_pass++;
      step();
    end
    idle_inputs();
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_mux_write();
    test_pc();
    test_scoreboard();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final pipeline stage, consuming the write-address and control fields that the third decode pipeline register presents. It selects the writeback data, then commits it to an 8-entry register file and to the program counter. It also keeps a pending-write scoreboard so decode can detect read-after-write hazards. It sits downstream of the decode/execute register chain and upstream of decode's operand read and hazard logic.

## Interface
Parameters:
- DATA_W, 16, register and datapath width
- PC_W, 16, program counter width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- writeAd_IN  in  3  destination register of the retiring instruction
- write_IN  in  1  register-file write enable
- ADR_MUX_IN  in  1  writeback source select: 0 = aluData_IN, 1 = memData_IN
- PC_load_IN  in  1  load PC from the selected writeback data
- aluData_IN  in  DATA_W  execute result
- memData_IN  in  DATA_W  memory read data
- stall_IN  in  1  hold PC (no increment)
- issueAd_IN  in  3  destination register of the instruction leaving decode
- issue_IN  in  1  decode issues an instruction that will write issueAd_IN
- readAdA_IN, readAdB_IN  in  3 each  operand read addresses
- readDataA_OUT, readDataB_OUT  out  DATA_W each  operand read data, combinational
- PC_OUT  out  PC_W  current program counter
- hazard_OUT  out  1  a read address targets a register with a pending write

## Operation
- wbData = ADR_MUX_IN ? memData_IN : aluData_IN.
- Register file:
  - R1..R7 are written with wbData at the edge when write_IN=1.
  - Writes to R0 are discarded; R0 always reads 0.
- PC update, by priority:
  - PC_load_IN=1: PC <= wbData, truncated or zero-extended to PC_W.
  - Else stall_IN=0: PC <= PC+1, wrapping modulo 2^PC_W.
  - Else PC holds.
  - PC_load_IN overrides stall_IN.
  - Register write and PC load are independent; both may occur in one cycle.
- Scoreboard, 8 pending bits:
  - issue_IN sets bit[issueAd_IN].
  - A retiring write (write_IN) clears bit[writeAd_IN].
  - Set and clear of the same register in one cycle: set wins, because a newer writer is in flight.
  - bit[0] is never set.
- hazard_OUT = pending[readAdA_IN] | pending[readAdB_IN], with R0 always excluded. See Configuration for bypass masking.

## Timing
- Reads and hazard_OUT are combinational from the addresses and current state; there is no read latency.
- Write-to-read latency is 1 cycle without bypass and 0 cycles with bypass.
- Scoreboard bit set at edge N is visible at hazard_OUT after edge N. A bit cleared at edge M is gone after edge M.
- Reset values:
  - All registers 0.
  - PC_OUT = 0.
  - Scoreboard all clear, so hazard_OUT = 0 and readData*_OUT = 0.
- RST asserted mid-operation clears all state immediately. Inputs are ignored while RST=1.
- The first PC increment occurs at the first rising edge after RST deasserts, if stall_IN=0.

## Configuration
- WB_BYPASS_EN defined:
  - A read port whose address equals writeAd_IN, while write_IN=1 and the address is nonzero, returns wbData combinationally.
  - That port's contribution to hazard_OUT is masked in the same cycle.
- WB_BYPASS_EN undefined:
  - Reads return stored contents only.
  - hazard_OUT stays asserted until the clearing edge has passed.

## Structure
- Shared package wb_pkg holds:
  - DATA_W, PC_W, and REG_AW=3 defaults.
  - Source-select constants WB_SEL_ALU=1'b0 and WB_SEL_MEM=1'b1.
  - The R0 index constant.
- One sub-module, wb_scoreboard: the 8-bit pending vector, set/clear priority, and hazard lookup including bypass masking.
- Register file, PC, and data mux live in writeback_unit.

## Test plan
- Reset check: assert RST mid-run with R3=0x1234, PC=0x0040 and R5 pending. Required: PC_OUT=0, all reads return 0, hazard_OUT=0 immediately.
- Mux and write: write_IN=1, writeAd_IN=3, ADR_MUX_IN=1, memData_IN=0xBEEF, aluData_IN=0x1111, readAdA_IN=3. Required: readDataA_OUT=0xBEEF after the edge, and same cycle only with WB_BYPASS_EN. Then a write to R0 with 0xFFFF leaves R0 reads at 0.
- PC sequence: stall_IN=0 for 3 cycles from reset gives PC 1,2,3. stall_IN=1 holds at 3. PC_load_IN=1 with aluData_IN=0x0100 and stall_IN=1 gives PC=0x0100. PC=0xFFFF increments to 0x0000.
- Scoreboard: issue R4, then read R4 gives hazard_OUT=1. Retire a write to R4 gives hazard_OUT=0 after the edge, or in the same cycle with WB_BYPASS_EN.
- Simultaneous events:
  - issue R2 and retire R2 in the same cycle leaves R2 pending (hazard_OUT=1).
  - issue R0 never raises hazard_OUT.
